// File: rtl/az_controller.sv
// az_controller: auto-zero sequencer on the initiator side of the ADC measure handshake.
// It switches azmux between the signal (HI) and zero (LO) inputs and waits for the input to settle.
// It triggers one measurement per phase and emits a stamped sample_valid pulse for each one.
//
// Handshake: adc_measure_start_o is held high for START_HOLD cycles to request a measurement.
// The adc drops adc_measure_done_i while it is busy. It then pulses done high for one cycle at
// completion. Only a done level seen in WAIT counts; a done level in IDLE/SETTLE/START is ignored.
module az_controller #(
  parameter logic [3:0]  AZMUX_HI       = 4'b0001,
  parameter logic [3:0]  AZMUX_LO       = 4'b0010,
  parameter logic [3:0]  AZMUX_OFF      = 4'b0000,
  parameter int unsigned START_HOLD     = 4,
  parameter int unsigned TIMEOUT_MARGIN = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic        az_mode_i,
  input  logic [31:0] clk_settle_duration_i,
  input  logic [31:0] clk_sample_duration_i,
  input  logic        adc_measure_done_i,
  output logic        adc_measure_start_o,
  output logic [3:0]  azmux_o,
  output logic        sample_valid_o,
  output logic        sample_is_hi_o,
  output logic [15:0] sample_seq_o,
  output logic        timeout_err_o,
  output logic [5:0]  monitor_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0]  HOLD_LOAD = 8'(START_HOLD - 1);
  localparam logic [32:0] MARGIN    = 33'(TIMEOUT_MARGIN);

  state_t      state_q, state_d;
  logic        phase_hi_q, phase_hi_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] tmo_q, tmo_d;
  logic        start_q, start_d;
  logic [3:0]  azmux_q, azmux_d;
  logic        valid_q, valid_d;
  logic        is_hi_q, is_hi_d;
  logic [15:0] seq_q, seq_d;
  logic        err_q, err_d;
  logic        run_q;
  logic [5:0]  mon_q, mon_d;

  logic [32:0] tmo_sum;
  logic [31:0] tmo_load;
  logic        run_rise;

  // Timeout load saturates instead of wrapping for very long sample durations.
  always_comb begin
    tmo_sum  = {1'b0, clk_sample_duration_i} + MARGIN;
    tmo_load = tmo_sum[32] ? 32'hFFFF_FFFF : tmo_sum[31:0];
    run_rise = run_i & ~run_q;
  end

  // State register and all registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      phase_hi_q <= 1'b0;
      cnt_q      <= '0;
      hold_q     <= '0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      azmux_q    <= AZMUX_OFF;
      valid_q    <= 1'b0;
      is_hi_q    <= 1'b0;
      seq_q      <= '0;
      err_q      <= 1'b0;
      run_q      <= 1'b0;
      mon_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_hi_q <= phase_hi_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      azmux_q    <= azmux_d;
      valid_q    <= valid_d;
      is_hi_q    <= is_hi_d;
      seq_q      <= seq_d;
      err_q      <= err_d;
      run_q      <= run_i;
      mon_q      <= mon_d;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    phase_hi_d = phase_hi_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    tmo_d      = tmo_q;
    start_d    = start_q;
    azmux_d    = azmux_q;
    valid_d    = 1'b0;
    is_hi_d    = is_hi_q;
    seq_d      = seq_q;
    err_d      = err_q;

    // A fresh run request clears a previous timeout; a new timeout below still wins.
    if (run_rise) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        azmux_d = AZMUX_OFF;
        if (run_i) begin
          phase_hi_d = 1'b1;
          azmux_d    = AZMUX_HI;
          cnt_d      = clk_settle_duration_i;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 32'd0) begin
          start_d = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_START: begin
        if (hold_q == 8'd0) begin
          start_d = 1'b0;
          tmo_d   = tmo_load;
          state_d = S_WAIT;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      S_WAIT: begin
        if (adc_measure_done_i) begin
          valid_d = 1'b1;
          is_hi_d = phase_hi_q;
          seq_d   = seq_q + 16'd1;
          state_d = S_DONE;
        end else if (tmo_q == 32'd0) begin
          err_d   = 1'b1;
          azmux_d = AZMUX_OFF;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q - 32'd1;
        end
      end
      S_DONE: begin
        if (!run_i) begin
          azmux_d = AZMUX_OFF;
          state_d = S_IDLE;
        end else if (az_mode_i) begin
          phase_hi_d = ~phase_hi_q;
          azmux_d    = phase_hi_q ? AZMUX_LO : AZMUX_HI;
          cnt_d      = clk_settle_duration_i;
          state_d    = S_SETTLE;
        end else if (!phase_hi_q) begin
          // Leaving alternate mode while on LO: return to HI and let it settle.
          phase_hi_d = 1'b1;
          azmux_d    = AZMUX_HI;
          cnt_d      = clk_settle_duration_i;
          state_d    = S_SETTLE;
        end else begin
          start_d = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = S_START;
        end
      end
      default: begin
        start_d = 1'b0;
        azmux_d = AZMUX_OFF;
        state_d = S_IDLE;
      end
    endcase

    mon_d = {err_d, (state_d == S_SETTLE), valid_d, is_hi_d, adc_measure_done_i, start_d};
  end

  assign adc_measure_start_o = start_q;
  assign azmux_o             = azmux_q;
  assign sample_valid_o      = valid_q;
  assign sample_is_hi_o      = is_hi_q;
  assign sample_seq_o        = seq_q;
  assign timeout_err_o       = err_q;
  assign monitor_o           = mon_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_az_controller.sv
// Bench for az_controller: directed sequences against a small behavioural adc model.
// Expected samples {azmux, is_hi, seq} are queued by the stimulus and checked by a monitor.
module tb_az_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        az_mode;
  logic [31:0] settle_dur;
  logic [31:0] sample_dur;
  logic        done;
  logic        start;
  logic [3:0]  azmux;
  logic        valid;
  logic        is_hi;
  logic [15:0] seq;
  logic        err;
  logic [5:0]  mon;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int settle_seen = 0;
  logic no_done = 1'b0;
  logic [20:0] exp_q[$];

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  az_controller dut (
    .clk_i                 (clk),
    .reset_i               (reset),
    .run_i                 (run),
    .az_mode_i             (az_mode),
    .clk_settle_duration_i (settle_dur),
    .clk_sample_duration_i (sample_dur),
    .adc_measure_done_i    (done),
    .adc_measure_start_o   (start),
    .azmux_o               (azmux),
    .sample_valid_o        (valid),
    .sample_is_hi_o        (is_hi),
    .sample_seq_o          (seq),
    .timeout_err_o         (err),
    .monitor_o             (mon),
    .state_o               (state)
  );

  // ---------------- adc model ----------------
  logic        adc_busy;
  logic [31:0] adc_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b1;
      adc_busy <= 1'b0;
      adc_cnt  <= '0;
    end else if (start) begin
      done     <= 1'b0;
      adc_busy <= 1'b1;
      adc_cnt  <= sample_dur;
    end else if (adc_busy) begin
      if (adc_cnt == 32'd0) begin
        adc_busy <= 1'b0;
        done     <= ~no_done;
      end else begin
        adc_cnt <= adc_cnt - 32'd1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] az, input logic hi, input logic [15:0] s);
    exp_q.push_back({az, hi, s});
  endtask

  initial begin
    logic [20:0] e;
    forever begin
      @(negedge clk);
      if (!reset && valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sample_unexpected got=%0h exp=none t=%0t", {azmux, is_hi, seq}, $time);
        end else begin
          e = exp_q.pop_front();
          if ({azmux, is_hi, seq} !== e) begin
            bad++;
            $display("FAIL sample got=%0h exp=%0h t=%0t", {azmux, is_hi, seq}, e, $time);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values();
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_azmux", {28'd0, azmux}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_is_hi", {31'd0, is_hi}, 32'd0);
    chk("rst_seq",   {16'd0, seq},   32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_mon",   {26'd0, mon},   32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
  endtask

  task automatic do_reset(input logic check);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (check) check_reset_values();
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Waits for the next sample_valid; drops run on that cycle if asked.
  task automatic wait_valid(input logic drop_run);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (mon[4]) settle_seen++;
      if (valid) break;
    end
    if (n == 3000) chk("wait_valid_timeout", 32'd1, 32'd0);
    else if (drop_run) run = 1'b0;
  endtask

  // Returns at the first negedge after adc_measure_start falls (controller in WAIT).
  task automatic wait_start_fall();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (start) break;
    end
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!start) break;
    end
    if (n == 3000) chk("start_fall_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s_cnt;
    int st_cnt;
    int n;
    reset = 1'b1; run = 1'b0; az_mode = 1'b0;
    settle_dur = 32'd3; sample_dur = 32'd10;

    // T1: alternate HI/LO, settle and start timing.
    do_reset(1'b1);
    az_mode = 1'b1;
    push(4'b0001, 1'b1, 16'd1);
    push(4'b0010, 1'b0, 16'd2);
    push(4'b0001, 1'b1, 16'd3);
    push(4'b0010, 1'b0, 16'd4);
    run = 1'b1;
    s_cnt = 0; st_cnt = 0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (mon[4]) s_cnt++;
      if (start) st_cnt++;
      else if (st_cnt > 0) break;
    end
    chk("t1_settle_cycles", s_cnt, 32'd4);
    chk("t1_start_cycles", st_cnt, 32'd4);
    repeat (3) wait_valid(1'b0);
    wait_valid(1'b1);
    repeat (2) @(negedge clk);
    chk("t1_idle_azmux", {28'd0, azmux}, 32'd0);
    chk("t1_idle_start", {31'd0, start}, 32'd0);
    chk("t1_idle_state", {29'd0, state}, 32'd0);

    // T2: HI only, no re-settle between samples.
    do_reset(1'b0);
    az_mode = 1'b0;
    for (int k = 1; k <= 5; k++) push(4'b0001, 1'b1, 16'(k));
    settle_seen = 0;
    run = 1'b1;
    repeat (4) wait_valid(1'b0);
    wait_valid(1'b1);
    chk("t2_settle_total", settle_seen, 32'd4);
    @(negedge clk);
    chk("t2_seq", {16'd0, seq}, 32'd5);

    // T3: run dropped during WAIT still reports that sample.
    do_reset(1'b0);
    az_mode = 1'b1;
    push(4'b0001, 1'b1, 16'd1);
    run = 1'b1;
    wait_start_fall();
    repeat (3) @(negedge clk);
    run = 1'b0;
    wait_valid(1'b0);
    repeat (2) @(negedge clk);
    chk("t3_azmux", {28'd0, azmux}, 32'd0);
    chk("t3_start", {31'd0, start}, 32'd0);
    chk("t3_state", {29'd0, state}, 32'd0);
    repeat (40) @(negedge clk);

    // T4: done never arrives -> timeout, then recovery on a new run.
    do_reset(1'b0);
    no_done = 1'b1;
    run = 1'b1;
    wait_start_fall();
    run = 1'b0;
    for (n = 1; n < 2000; n++) begin
      @(negedge clk);
      if (err) break;
    end
    chk("t4_timeout_cycles", n, 32'd1035);
    chk("t4_azmux", {28'd0, azmux}, 32'd0);
    chk("t4_mon", {26'd0, mon}, 32'h20);
    no_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    run = 1'b1;
    @(negedge clk);
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    chk("t4_restart_hi", {28'd0, azmux}, 32'd1);
    push(4'b0001, 1'b1, 16'd1);
    wait_valid(1'b1);

    // T5: reset mid-START and mid-WAIT.
    do_reset(1'b0);
    az_mode = 1'b1;
    push(4'b0001, 1'b1, 16'd1);
    run = 1'b1;
    wait_valid(1'b0);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (start) break;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values();
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run = 1'b1;
    wait_start_fall();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_wait_azmux", {28'd0, azmux}, 32'd0);
    chk("t5_wait_start", {31'd0, start}, 32'd0);
    chk("t5_wait_mon", {26'd0, mon}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // T6: sequence counter wraps 0xFFFF -> 0.
    do_reset(1'b0);
    settle_dur = 32'd0; sample_dur = 32'd0; az_mode = 1'b0;
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.seq_q;
    push(4'b0001, 1'b1, 16'h0000);
    push(4'b0001, 1'b1, 16'h0001);
    run = 1'b1;
    wait_valid(1'b0);
    wait_valid(1'b1);
    repeat (5) @(negedge clk);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
